display_sequencer: RTL and testbench
====================================

# display_sequencer

Generates the eight 4-bit digit values that drive the board's eight seven-segment decoders (digit 0 → HEX7 … digit 7 → HEX0). It holds a ring of eight nibbles that rotates one position per advance event. Advances come from either a free-running prescaled tick (RUN mode) or a debounced push-button press (STOP mode), and each digit is individually blanked to 0 by its enable switch. It sits between the board inputs (SW/KEY) and the display decoder stage.

## Interface

Parameters:
- TICK_DIV, 50_000_000 — CLOCK_50 cycles per RUN-mode advance; legal range ≥ 2.
- DEBOUNCE_CYCLES, 1_000_000 — consecutive cycles the synchronised button level must differ from the stable level before it is accepted; legal range ≥ 1.

Ports:
- CLOCK_50 input 1 — sole clock; all state updates on its rising edge.
- reset input 1 — synchronous, active-high.
- enable_sw input 8 — bit i high shows ring digit i; low forces digit i to 4'h0.
- run_sw input 1 — asynchronous level: 1 selects RUN, 0 selects STOP.
- step_n input 1 — asynchronous push button, active-low (KEY style).
- digits output 32 — digit i on [4i+3:4i].
- tick output 1 — one-cycle pulse on each RUN-mode advance.
- running output 1 — current mode register (1 = RUN).
- phase output 3 — advances since reset, mod 8.

## Operation

- Synchronisers: run_sw and step_n each pass through two flops before use. Reset values are run 0 and step 1.
- Ring: eight 4-bit registers, reset to ring[i] = i.
  - Advance: ring[i] ← old ring[(i+1) mod 8], so digit 7 takes the old digit 0.
  - phase increments by 1 on every advance and wraps 7 → 0.
  - phase always equals ring[0].
- digits: combinational. digits[4i+3:4i] = enable_sw[i] ? ring[i] : 4'h0. It has no latency from enable_sw.
- Mode register `running`: loads the synchronised run_sw every cycle, and resets to 0.
- Prescaler: counts 0..TICK_DIV-1.
  - It is held at 0 while running = 0.
  - At count TICK_DIV-1 with running = 1, it asserts tick for that cycle, the ring advances at that edge, and the count returns to 0.
- Debouncer: holds a stable level (reset value 1) and a counter (reset value 0).
  - While synchronised step ≠ stable, the counter increments.
  - When it equals DEBOUNCE_CYCLES-1 and still differs, stable ← synchronised step and the counter clears.
  - Any cycle with synchronised step = stable clears the counter.
- Press event: stable transitioning 1 → 0 while running = 0. The ring advances on the same edge that stable updates.
- Releases (0 → 1) never advance the ring.
- Presses accepted while running = 1 are ignored, but the debouncer still tracks the level.
- Mode switch: a RUN → STOP change abandons any partial prescaler count. A STOP → RUN change starts counting from 0.
- Only one advance source is ever active, so a tick and a press event can never both advance the ring in the same cycle.

## Timing

- Reset: on the edge where reset = 1, all state returns to its reset value. This applies mid-rotation and mid-debounce.
  - After reset: ring = 0..7, phase = 0, tick = 0, running = 0, prescaler = 0, debounce counter = 0, stable = 1.
  - With enable_sw = 8'hFF, digits = 32'h76543210.
- Button latency: let edge E0 be the first edge that samples step_n low. The ring, phase and digits show the advance after edge E(DEBOUNCE_CYCLES+1), provided step_n stays low throughout.
- A bounce (step_n high for one cycle) before that edge restarts the count.
- run_sw latency: running changes 2 edges after run_sw changes.
- RUN cadence: the first tick occurs TICK_DIV cycles after running rises, then every TICK_DIV cycles.

## Test plan

Run the bench with TICK_DIV = 4 and DEBOUNCE_CYCLES = 3.

1. Reset with enable_sw = 8'hFF → digits = 32'h76543210, phase = 0, running = 0, tick = 0.
2. run_sw = 1 held for 12 cycles after running rises → exactly 3 tick pulses, 4 cycles apart. Final digits = 32'h21076543, phase = 3.
3. STOP mode: step_n low for 10 cycles, then high → exactly one advance at E4, digits = 32'h07654321. Release causes no change.
4. Bounce: step_n low 2 cycles, high 1, low 2, high → no advance, phase unchanged.
5. enable_sw = 8'b0000_0101 after reset → digits = 32'h00000200. Toggling bit 2 changes digits the same cycle.
6. Reset asserted mid-RUN with phase = 5 → next cycle digits = 32'h76543210, phase = 0, tick = 0, running = 0 until run_sw re-synchronises.

Source files
------------

// File: rtl/display_sequencer.sv
// display_sequencer
//   Rotates a ring of eight 4-bit digit values feeding the eight seven-segment
//   decoders (digit 0 -> HEX7 ... digit 7 -> HEX0). The ring advances either on
//   a prescaled free-running tick (RUN mode) or on a debounced press of the
//   active-low step button (STOP mode). Each digit can be blanked to 0 by its
//   enable switch.
//
// Ports
//   CLOCK_50  : sole clock, rising edge
//   reset     : synchronous, active-high
//   enable_sw : bit i shows ring digit i, low forces digit i to 0
//   run_sw    : asynchronous mode switch, 1 = RUN, 0 = STOP
//   step_n    : asynchronous push button, active-low
//   digits    : digit i on [4i+3:4i], combinational from ring and enable_sw
//   tick      : one-cycle pulse on each RUN-mode advance
//   running   : current mode register (1 = RUN)
//   phase     : advances since reset, mod 8 (always equal to ring[0])
module display_sequencer #(
  parameter int TICK_DIV        = 50_000_000,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic [7:0]  enable_sw,
  input  logic        run_sw,
  input  logic        step_n,
  output logic [31:0] digits,
  output logic        tick,
  output logic        running,
  output logic [2:0]  phase
);

  localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);

  logic              run_meta;
  logic              step_meta;
  logic              step_sync;
  logic              stable;
  logic [DB_W-1:0]   db_cnt;
  logic [TICK_W-1:0] presc;
  logic [3:0]        ring [8];

  logic db_differ;
  logic db_accept;
  logic press;
  logic advance;

  // running doubles as the second synchroniser stage of run_sw, so the mode
  // follows the switch two edges later.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      run_meta  <= 1'b0;
      running   <= 1'b0;
      step_meta <= 1'b1;
      step_sync <= 1'b1;
    end else begin
      run_meta  <= run_sw;
      running   <= run_meta;
      step_meta <= step_n;
      step_sync <= step_meta;
    end
  end

  // Debouncer: the synchronised level must differ from the stable level for
  // DEBOUNCE_CYCLES consecutive cycles before it is accepted.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      stable <= 1'b1;
      db_cnt <= '0;
    end else if (!db_differ) begin
      db_cnt <= '0;
    end else if (db_cnt == DB_LAST) begin
      stable <= step_sync;
      db_cnt <= '0;
    end else begin
      db_cnt <= db_cnt + DB_W'(1);
    end
  end

  // Prescaler is held at 0 outside RUN, so a mode change always restarts it.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      presc <= '0;
    end else if (!running) begin
      presc <= '0;
    end else if (presc == TICK_LAST) begin
      presc <= '0;
    end else begin
      presc <= presc + TICK_W'(1);
    end
  end

  // Ring rotates towards digit 0: digit 7 receives the old digit 0.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      for (int unsigned i = 0; i < 8; i++) begin
        ring[3'(i)] <= 4'(i);
      end
      phase <= '0;
    end else if (advance) begin
      for (int unsigned i = 0; i < 8; i++) begin
        ring[3'(i)] <= ring[3'(i + 1)];
      end
      phase <= phase + 3'd1;
    end
  end

  always_comb begin
    db_differ = (step_sync != stable);
    db_accept = db_differ && (db_cnt == DB_LAST);
    // Only a 1 -> 0 acceptance of the stable level counts as a press.
    press     = db_accept && stable && !running;
    tick      = running && (presc == TICK_LAST);
    advance   = tick || press;
  end

  always_comb begin
    digits = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      digits[4*i +: 4] = enable_sw[3'(i)] ? ring[3'(i)] : 4'h0;
    end
  end

endmodule

// File: tb/tb_display_sequencer.sv
// tb_display_sequencer
//   Scoreboard bench for display_sequencer with TICK_DIV = 4 and
//   DEBOUNCE_CYCLES = 3. Stimulus tasks predict each ring advance (cycle,
//   resulting phase, source) and queue it; a monitor sampling 2 time units
//   after every rising edge pops and compares whenever the DUT phase moves,
//   and checks digits, tick and running every cycle. Expected digits come from
//   the rotation offset: digit i = (i + phase) mod 8 when enabled.
module tb_display_sequencer;

  localparam int TD = 4;
  localparam int DB = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  enable_sw = 8'hFF;
  logic        run_sw = 1'b0;
  logic        step_n = 1'b1;
  logic [31:0] digits;
  logic        tick;
  logic        running;
  logic [2:0]  phase;

  display_sequencer #(
    .TICK_DIV(TD),
    .DEBOUNCE_CYCLES(DB)
  ) dut (
    .CLOCK_50(clk),
    .reset(reset),
    .enable_sw(enable_sw),
    .run_sw(run_sw),
    .step_n(step_n),
    .digits(digits),
    .tick(tick),
    .running(running),
    .phase(phase)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned cyc;
    logic [2:0]  ph;
    bit          is_tick;
  } ev_t;

  ev_t         sbq[$];
  ev_t         ev;
  int          checks = 0;
  int          failures = 0;
  int unsigned cyc = 0;
  logic [2:0]  exp_phase = 3'd0;
  logic [2:0]  mon_phase = 3'd0;
  logic [2:0]  last_phase = 3'd0;
  bit          chk_en = 1'b0;
  bit          prev_tick = 1'b0;
  bit          h_meta = 1'b0;
  bit          h_run = 1'b0;
  bit          exp_tick;

  function automatic logic [31:0] model_digits(input logic [2:0] ph, input logic [7:0] en);
    logic [31:0] d;
    d = '0;
    for (int i = 0; i < 8; i++) begin
      if (en[i]) d[4*i +: 4] = 4'((i + int'(ph)) % 8);
    end
    return d;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void push(input int unsigned e, input bit is_tick);
    exp_phase = exp_phase + 3'd1;
    sbq.push_back('{cyc: e, ph: exp_phase, is_tick: is_tick});
  endfunction

  // Monitor: edge counter, mode-register shadow and all per-cycle checks.
  always begin
    @(posedge clk);
    cyc++;
    if (reset) begin
      h_meta = 1'b0;
      h_run  = 1'b0;
    end else begin
      h_run  = h_meta;
      h_meta = run_sw;
    end
    #2;
    if (chk_en) begin
      while (sbq.size() > 0 && sbq[0].cyc < cyc) begin
        checks++;
        failures++;
        $display("FAIL missed_advance: no phase change observed, expected at cycle %0d (now %0d)", sbq[0].cyc, cyc);
        mon_phase = sbq[0].ph;
        void'(sbq.pop_front());
      end
      if (phase != last_phase) begin
        if (sbq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_advance: phase %0d -> %0d, none expected (cycle %0d)", last_phase, phase, cyc);
        end else begin
          ev = sbq.pop_front();
          check("advance_cycle", cyc, ev.cyc);
          check("advance_phase", 32'(phase), 32'(ev.ph));
          check("advance_source", 32'(prev_tick), 32'(ev.is_tick));
          mon_phase = ev.ph;
        end
      end
      exp_tick = (sbq.size() > 0) && (sbq[0].cyc == cyc + 1) && sbq[0].is_tick;
      check("tick", 32'(tick), 32'(exp_tick));
      check("running", 32'(running), 32'(h_run));
      check("digits", digits, model_digits(mon_phase, enable_sw));
    end
    last_phase = phase;
    prev_tick  = tick;
  end

  task automatic do_reset(input logic [7:0] en, input logic [31:0] exp_digits);
    chk_en    = 1'b0;
    enable_sw = en;
    step_n    = 1'b1;
    reset     = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_digits", digits, exp_digits);
    check("reset_phase", 32'(phase), 32'd0);
    check("reset_tick", 32'(tick), 32'd0);
    check("reset_running", 32'(running), 32'd0);
    reset     = 1'b0;
    sbq.delete();
    exp_phase = 3'd0;
    mon_phase = 3'd0;
    chk_en    = 1'b1;
  endtask

  // r: edge after which running is 1; run_sw is dropped so that it is sampled
  // at edge r + q_off, making edge r + q_off + 1 the last possible tick advance.
  task automatic run_hold(input int unsigned r, input int unsigned q_off);
    int unsigned q;
    q = r + q_off;
    for (int unsigned e = r + TD; e <= q + 1; e += TD) push(e, 1'b1);
    while (cyc < q - 1) @(negedge clk);
    run_sw = 1'b0;
    repeat (TD + 3) @(negedge clk);
  endtask

  task automatic run_episode(input int unsigned q_off);
    run_sw = 1'b1;
    run_hold(cyc + 2, q_off);
  endtask

  // Low for l cycles then high for h cycles; an accepted press advances at
  // E0 + DB + 1 where E0 is the first edge sampling the low level.
  task automatic press_trial(input int unsigned l, input int unsigned h, input bit expect_adv);
    step_n = 1'b0;
    if (expect_adv && l >= DB) push(cyc + 1 + DB + 1, 1'b0);
    repeat (l) @(negedge clk);
    step_n = 1'b1;
    repeat (h) @(negedge clk);
  endtask

  initial begin
    int unsigned l;
    int unsigned r6;

    do_reset(8'hFF, 32'h76543210);

    // Single debounced press, then a release that must not advance.
    press_trial(10, DB + 4, 1'b1);
    check("press_digits", digits, 32'h07654321);
    check("press_phase", 32'(phase), 32'd1);

    // Bouncing button: two short lows never reach the debounce count.
    press_trial(2, 1, 1'b1);
    press_trial(2, DB + 4, 1'b1);
    check("bounce_phase", 32'(phase), 32'd1);
    check("bounce_digits", digits, 32'h07654321);

    // RUN for 12 cycles: three ticks.
    do_reset(8'hFF, 32'h76543210);
    run_episode(11);
    check("run_digits", digits, 32'h21076543);
    check("run_phase", 32'(phase), 32'd3);

    // Press while running is tracked but ignored.
    fork
      run_episode(20);
      begin
        repeat (3) @(negedge clk);
        press_trial(5, DB + 4, 1'b0);
      end
    join

    // Per-digit blanking is combinational.
    do_reset(8'b0000_0101, 32'h00000200);
    enable_sw = 8'b0000_0001;
    #1 check("enable_toggle_off", digits, 32'h00000000);
    enable_sw = 8'b0000_0101;
    #1 check("enable_toggle_on", digits, 32'h00000200);
    @(negedge clk);

    // Randomised mix of RUN episodes and button trials.
    for (int t = 0; t < 30; t++) begin
      enable_sw = 8'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        run_episode($urandom_range(0, 14));
      end else begin
        l = $urandom_range(1, DB + 4);
        press_trial(l, (l >= DB) ? $urandom_range(DB + 3, DB + 6) : $urandom_range(1, 3), 1'b1);
      end
    end

    // Reset in the middle of RUN at phase 5, then run_sw resynchronises.
    do_reset(8'hFF, 32'h76543210);
    run_sw = 1'b1;
    r6 = cyc + 2;
    for (int unsigned j = 1; j <= 5; j++) push(r6 + TD * j, 1'b1);
    while (cyc < r6 + TD * 5 + 1) @(negedge clk);
    check("midrun_phase", 32'(phase), 32'd5);
    do_reset(8'hFF, 32'h76543210);
    run_hold(cyc + 2, 7);
    check("midrun_restart_phase", 32'(phase), 32'd2);

    check("scoreboard_drained", sbq.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached (cycle %0d)", cyc);
    $fatal(1);
  end

endmodule
